// File: rtl/flex_counter_pkg.sv
// rtl/flex_counter_pkg.sv - shared types and constants for the flex counter
package flex_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/flex_counter_next.sv
// rtl/flex_counter_next.sv - combinational next-count, wrap and terminal logic
module flex_counter_next
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic [NUM_CNT_BITS-1:0] i_count,
    input  cnt_state_t              i_state,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic                    i_count_enable,
    input  logic                    i_count_down,
    input  logic                    i_mode,
    input  logic [NUM_CNT_BITS-1:0] i_load_val,
    input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
    output logic [NUM_CNT_BITS-1:0] o_next_count,
    output cnt_state_t              o_next_state,
    output logic                    o_wrap,
    output logic                    o_flag,
    output logic                    o_done
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic                    w_step_en;
    logic                    w_at_term;
    logic [NUM_CNT_BITS-1:0] w_reload;
    logic [NUM_CNT_BITS-1:0] w_tv;

    // A zero rollover value freezes counting; load and clear stay live.
    assign w_step_en = i_count_enable && (i_rollover_val != '0);

    // Out-of-range values (above rollover going up, zero going down) count as terminal.
    assign w_at_term = (i_count_down == DIR_DOWN) ? (i_count <= ONE)
                                                  : (i_count >= i_rollover_val);

    // Value entered on a wrap, and also the first step out of IDLE.
    assign w_reload = (i_count_down == DIR_DOWN) ? i_rollover_val : ONE;

    // Terminal value for the direction being presented on this edge.
    assign w_tv = (i_count_down == DIR_DOWN) ? ONE : i_rollover_val;

    // Priority: clear > load > enabled step > hold.
    always_comb begin
        o_next_count = i_count;
        o_next_state = i_state;
        o_wrap       = 1'b0;
        o_done       = (i_state == DONE);
        if (i_clear) begin
            o_next_count = '0;
            o_next_state = IDLE;
            o_done       = 1'b0;
        end else if (i_load) begin
            o_next_count = i_load_val;
            o_next_state = RUN;
            o_done       = 1'b0;
        end else if (w_step_en) begin
            case (i_state)
                IDLE: begin
                    o_next_count = w_reload;
                    o_next_state = RUN;
                end
                RUN: begin
                    if (w_at_term) begin
                        if (i_mode == MODE_ONESHOT) begin
                            o_next_state = DONE;
                            o_done       = 1'b1;
                        end else begin
                            o_next_count = w_reload;
                            o_wrap       = 1'b1;
                        end
                    end else if (i_count_down == DIR_DOWN) begin
                        o_next_count = i_count - ONE;
                    end else begin
                        o_next_count = i_count + ONE;
                    end
                end
                default: begin
                    o_next_state = i_state;
                end
            endcase
        end
    end

    // Flag is computed on the next count so it lines up with count_out.
    assign o_flag = (o_next_count == w_tv) && (w_tv != '0);

endmodule

// File: rtl/flex_counter_mode.sv
// rtl/flex_counter_mode.sv - up/down wrap or one-shot counter with load and clear
module flex_counter_mode
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    mode,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    done,
    output logic                    busy
);

    cnt_state_t              r_state;
    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic                    r_wrap;
    logic                    r_done;

    cnt_state_t              w_next_state;
    logic [NUM_CNT_BITS-1:0] w_next_count;
    logic                    w_wrap;
    logic                    w_flag;
    logic                    w_done;

    flex_counter_next #(
        .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_next (
        .i_count       (r_count),
        .i_state       (r_state),
        .i_clear       (clear),
        .i_load        (load),
        .i_count_enable(count_enable),
        .i_count_down  (count_down),
        .i_mode        (mode),
        .i_load_val    (load_val),
        .i_rollover_val(rollover_val),
        .o_next_count  (w_next_count),
        .o_next_state  (w_next_state),
        .o_wrap        (w_wrap),
        .o_flag        (w_flag),
        .o_done        (w_done)
    );

    // State machine and registered outputs, all updated together on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_flag  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_flag  <= w_flag;
            r_wrap  <= w_wrap;
            r_done  <= w_done;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign wrap_pulse    = r_wrap;
    assign done          = r_done;
    assign busy          = (r_state == RUN);

endmodule
